// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: computes a W-bit sum over NIBBLES clock cycles.
// Each cycle one nibble pair goes through a combinational 4-bit CLA stage,
// and the carry is chained from one cycle to the next.

// 4-bit carry-lookahead stage; purely combinational
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // generate/propagate terms with carries expanded in lookahead form
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [3:0]       nib_sum;
    logic             nib_c;
    // nib_sum concatenated above sum_q; dropping the low nibble shifts the
    // result right by one nibble, and this works even when W is 4
    logic [W+3:0]     sum_shift;

    cla4 u_cla4 (
        .a  (op_a_q[3:0]),
        .b  (op_b_q[3:0]),
        .ci (carry_q),
        .s  (nib_sum),
        .co (nib_c)
    );

    // next-state and datapath logic: capture, shift/accumulate, finish
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        sum_shift = {nib_sum, sum_q};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = sum_shift[W+3:4];
                carry_d = nib_c;
                op_a_d  = op_a_q >> 4;
                op_b_d  = op_b_q >> 4;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_c;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state registers; reset abandons any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
